// File: rtl/test_1_pkg.sv
// Shared constants and state type for the serial pattern-lock detector.
package test_1_pkg;

  localparam logic [5:0] UNLOCK_CODE = 6'b110100;
  localparam int         CODE_LEN    = 6;

  // Each state names the prefix of UNLOCK_CODE matched so far.
  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5
  } state_e;

endpackage

// File: rtl/test_1_if.sv
// Serial key bit in, unlock indication out.
interface test_1_if;

  logic d_in;
  logic unlock;

  modport master (output d_in, input  unlock);
  modport slave  (input  d_in, output unlock);

endinterface

// File: rtl/test_1.sv
// Serial 110100 pattern-lock detector; define UNLOCK_REG_EN to register the
// unlock output (one-cycle latency) instead of the combinational Mealy output.
module test_1
  import test_1_pkg::*;
(
  input  logic     clk,
  input  logic     clear,
  test_1_if.slave  bus
);

  state_e state_q;
  state_e state_d;
  logic   hit;

  always_comb begin
    state_d = S0;
    case (state_q)
      S0:      state_d = bus.d_in ? S1 : S0;
      S1:      state_d = bus.d_in ? S2 : S0;
      S2:      state_d = bus.d_in ? S2 : S3;
      S3:      state_d = bus.d_in ? S4 : S0;
      S4:      state_d = bus.d_in ? S2 : S5;
      S5:      state_d = bus.d_in ? S1 : S0;
      default: state_d = S0;
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) state_q <= S0;
    else        state_q <= state_d;
  end

  // The sixth bit is being presented while in S5.
  assign hit = (state_q == S5) && !bus.d_in;

`ifdef UNLOCK_REG_EN
  logic unlock_q;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) unlock_q <= 1'b0;
    else        unlock_q <= hit;
  end

  assign bus.unlock = unlock_q;
`else
  assign bus.unlock = hit;
`endif

endmodule

// File: tb/tb_test_1.sv
// Scoreboard bench for test_1: bit-history string match as the reference model.
module tb_test_1;
  import test_1_pkg::*;

  logic clk;
  logic clear;
  int   checks;
  int   errors;
  int   cyc;
  bit   hist[$];
  logic exp_q[$];

  test_1_if bus();

  test_1 dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // True when the bit history ends in the full unlock code.
  function automatic bit ends_with_code(input bit h[$]);
    logic [5:0] w;
    w = '0;
    if (h.size() < CODE_LEN) return 1'b0;
    for (int i = 0; i < CODE_LEN; i++)
      w = {w[4:0], h[h.size() - CODE_LEN + i]};
    return (w == UNLOCK_CODE);
  endfunction

  // One clock: record the bit consumed at the edge, then present the next bit.
  task automatic step(input logic b, input logic clr_n);
    bit   tmp[$];
    logic e;
    @(posedge clk);
    if (clear) begin
      hist.push_back(bus.d_in);
      if (hist.size() > CODE_LEN) void'(hist.pop_front());
    end
    #1;
    clear    = clr_n;
    bus.d_in = b;
    if (!clr_n) hist.delete();
`ifdef UNLOCK_REG_EN
    e = clr_n && ends_with_code(hist);
`else
    tmp = hist;
    tmp.push_back(b);
    e = clr_n && ends_with_code(tmp);
`endif
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b1);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) begin
      logic e;
      e = exp_q.pop_front();
      checks++;
      if (bus.unlock !== e) begin
        errors++;
        $display("FAIL unlock cyc=%0d got=%b exp=%b", cyc, bus.unlock, e);
      end
    end
  end

  initial begin
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    clear    = 1'b0;
    bus.d_in = 1'b0;

    // Held in reset with the input toggling.
    for (int i = 0; i < 6; i++) step(logic'(i % 2), 1'b0);

    send(16'b110100, 6);
    send(16'b1, 1);
    send(16'b1110100, 7);
    send(16'b110101, 6);
    send(16'b10100, 5);
    send(16'b1100, 4);
    send(16'b110100110100, 12);
    send(16'b0, 1);

    // Partial code discarded by an asynchronous clear between edges.
    send(16'b11010, 5);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    send(16'b00, 2);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0)      send(16'b110100, 6);
      else if ($urandom_range(60) == 0) step(1'($urandom_range(1)), 1'b0);
      else                             step(1'($urandom_range(1)), 1'b1);
    end
    send(16'b000, 3);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/test_1.md
# test_1

Serial pattern-lock detector. Watches a one-bit serial input sampled on each rising clock edge and asserts `unlock` when the 6-bit code 1-1-0-1-0-0 (first bit first) has been received. Overlapping occurrences are detected. The block is a leaf in the digital-lock datapath, between the serial key-entry front end and the lock actuator control.

## Interface
- No parameters. The code 6'b110100 is a fixed package constant.
- `clk`    input   1  system clock; all state updates on the rising edge.
- `clear`  input   1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- `d_in`   input   1  serial code bit, sampled at the rising edge of `clk`.
- `unlock` output  1  code-detected indication.

## Operation
- Moore-encoded state register with a Mealy output.
- States and the prefix each one represents:
  - S0: none
  - S1: "1"
  - S2: "11"
  - S3: "110"
  - S4: "1101"
  - S5: "11010"
- Transitions (d_in=0 / d_in=1):
  - S0: S0 / S1
  - S1: S0 / S2
  - S2: S3 / S2
  - S3: S0 / S4
  - S4: S5 / S2
  - S5: S0 / S1
- Default mode: `unlock = (state == S5) && (d_in == 0)`, combinational. It is high while the sixth bit is presented, ahead of the edge that consumes it.
- After a detection the FSM returns to S0. No proper suffix of 110100 is a prefix of it, so overlap never shortens the next detection.
- Any 3-bit state encoding may be used. Unused encodings go to S0 on the next edge, with `unlock` = 0.
- `clear` low forces the state to S0 immediately, independent of `clk`, and forces `unlock` to 0. Reset mid-sequence discards the partial code.

## Timing
- Reset values: state = S0, `unlock` = 0.
- Default mode: zero-cycle latency from `d_in` to `unlock` while in S5. `d_in` must be stable for setup and hold around the rising edge.
- `unlock` is high for at most one clock period per detection.
- Release of `clear` is synchronous in effect: the first bit is sampled on the first rising edge with `clear` high.

## Configuration
- `UNLOCK_REG_EN` defined: `unlock` comes from a flop.
  - The flop is set on the rising edge that samples the final 0 while in S5.
  - It is high for exactly one cycle after that edge (one-cycle latency, glitch-free).
  - It is cleared asynchronously by `clear`.
- `UNLOCK_REG_EN` undefined: combinational Mealy output as described under Operation.

## Structure
- Package `test_1_pkg`:
  - state enum type (S0..S5, 3-bit)
  - constant `UNLOCK_CODE` = 6'b110100
  - constant `CODE_LEN` = 6
- Single module. No sub-module is warranted.
- Next-state logic is one `always_comb` case statement. The state flop is an async-reset `always_ff`.

## Test plan
- Reset: `clear`=0 with `d_in` toggling -> state S0, `unlock`=0 throughout. Release `clear`, then feed 110100 -> `unlock`=1 on the sixth bit.
- Basic detection: bits 1,1,0,1,0,0 after reset -> `unlock` 0 for bits 1-5, 1 while the sixth bit (0) is presented (one cycle later with `UNLOCK_REG_EN`). Then feed 1 -> `unlock`=0.
- Overlap / self-loop: bits 1,1,1,0,1,0,0 -> single `unlock` pulse on the final 0 (S2 self-loop on 111).
- Near-misses: 110101 then 10100 -> pulse only at the end of the second group (S5 on 1 goes to S1, then 1->S2...). Also 1100 returns to S0 with no pulse.
- Back-to-back codes: 110100110100 -> exactly two pulses, six cycles apart.
- Mid-sequence reset: 11010, assert `clear` asynchronously between edges, release, feed 0 -> no pulse, state S0.
